// File: rtl/fu_arbiter.sv
// fu_arbiter: per-cycle issue scheduler between the issue queue and the
// execution units. Grants each issuable slot one function unit, tracks the
// unpipelined divider's busy window and the LSU queue credits, and flushes
// all in-flight state on a commit redirect.
// Optional build macro FU_ARB_PERF_EN adds per-class stall counters (perf_stall).
// FU class bit order: 0 ALU, 1 BRU, 2 MUL, 3 DIV, 4 LSU.
module fu_arbiter #(
    parameter int unsigned iwd         = 4,
    parameter int unsigned nalu        = 2,
    parameter int unsigned nlsu        = 2,
    parameter int unsigned div_lat     = 16,
    parameter int unsigned lsu_credits = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               redir,
    input  logic [iwd-1:0]                     req_valid,
    input  logic [iwd*5-1:0]                   req_fu,
    input  logic [$clog2(lsu_credits+1)-1:0]   lsu_release,
    output logic [4:0]                         fu_ready,
    output logic [iwd-1:0]                     issue,
    output logic [iwd*5-1:0]                   grant_fu,
    output logic [$clog2(lsu_credits+1)-1:0]   lsu_avail
`ifdef FU_ARB_PERF_EN
    ,
    output logic [5*32-1:0]                    perf_stall
`endif
);

    localparam int unsigned NFU = 5;
    localparam int unsigned CW  = $clog2(lsu_credits + 1);
    localparam int unsigned DW  = $clog2(div_lat);
    localparam int unsigned BW  = 8;
    localparam int unsigned SW  = CW + BW + 1;
    localparam int unsigned FU_DIV = 3;
    localparam int unsigned FU_LSU = 4;

    logic [DW-1:0]  div_cnt_q, div_cnt_d;
    logic [CW-1:0]  credits_q, credits_d;
    logic [4:0]     fu_ready_q, fu_ready_d;

    logic [iwd-1:0]     issue_w;
    logic [iwd*5-1:0]   grant_w;
    logic [BW-1:0]      budget [NFU];
    logic [BW-1:0]      lsu_grants;
    logic               div_grant;
    logic               found;
    logic [NFU-1:0]     denied;
    logic [SW-1:0]      cred_sum;
    logic               cred_ovf;

`ifdef FU_ARB_PERF_EN
    logic [5*32-1:0]    perf_q, perf_d;
`endif

    // Oldest-first arbitration: each valid slot takes its lowest-index FU class with budget left
    always_comb begin
        issue_w    = '0;
        grant_w    = '0;
        lsu_grants = '0;
        div_grant  = 1'b0;
        found      = 1'b0;
        denied     = '0;
        budget[0]  = BW'(nalu);
        budget[1]  = BW'(1);
        budget[2]  = BW'(1);
        budget[3]  = (div_cnt_q == '0) ? BW'(1) : BW'(0);
        budget[4]  = (BW'(nlsu) < BW'(credits_q)) ? BW'(nlsu) : BW'(credits_q);
        if (!rst && !redir) begin
            for (int i = 0; i < int'(iwd); i++) begin
                found = 1'b0;
                if (req_valid[i]) begin
                    for (int f = 0; f < int'(NFU); f++) begin
                        if (!found && req_fu[i*NFU + f] && (budget[f] != '0)) begin
                            found            = 1'b1;
                            budget[f]        = budget[f] - BW'(1);
                            issue_w[i]       = 1'b1;
                            grant_w[i*NFU+f] = 1'b1;
                            if (f == int'(FU_LSU)) lsu_grants = lsu_grants + BW'(1);
                            if (f == int'(FU_DIV)) div_grant  = 1'b1;
                        end
                    end
                    if (!found) denied = denied | req_fu[i*NFU +: NFU];
                end
            end
        end
    end

    // Next divider occupancy, LSU credits and state-derived ready vector
    always_comb begin
        div_cnt_d = div_cnt_q;
        credits_d = credits_q;
        cred_sum  = SW'(credits_q) + SW'(lsu_release) - SW'(lsu_grants);
        cred_ovf  = (cred_sum > SW'(lsu_credits));
        if (redir) begin
            div_cnt_d = '0;
            credits_d = CW'(lsu_credits);
        end else begin
            if (div_grant) begin
                div_cnt_d = DW'(div_lat - 1);
            end else if (div_cnt_q != '0) begin
                div_cnt_d = div_cnt_q - DW'(1);
            end
            credits_d = cred_ovf ? CW'(lsu_credits) : CW'(cred_sum);
        end
        fu_ready_d = {(credits_d != '0), (div_cnt_d == '0), 3'b111};
    end

`ifdef FU_ARB_PERF_EN
    // Stall counters: one increment per class per cycle when any valid slot wanting it was denied
    always_comb begin
        perf_d = perf_q;
        for (int c = 0; c < int'(NFU); c++) begin
            if (denied[c]) perf_d[c*32 +: 32] = perf_q[c*32 +: 32] + 32'(1);
        end
    end
`endif

    // State registers with synchronous reset; credit overflow is a protocol error upstream
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            credits_q  <= CW'(lsu_credits);
            fu_ready_q <= 5'b11111;
        end else begin
            div_cnt_q  <= div_cnt_d;
            credits_q  <= credits_d;
            fu_ready_q <= fu_ready_d;
            if (!redir) begin
                assert (!cred_ovf) else $error("fu_arbiter: LSU credit overflow");
            end
        end
    end

`ifdef FU_ARB_PERF_EN
    // Counters survive redirects; only reset clears them
    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_stall = perf_q;
`endif

    assign issue     = issue_w;
    assign grant_fu  = grant_w;
    assign fu_ready  = fu_ready_q;
    assign lsu_avail = credits_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// Scoreboard bench for fu_arbiter: a driver issues directed and random
// traffic, a cycle-level reference model pushes expected outputs into a
// queue, and a monitor pops and compares on the falling edge.
module tb_fu_arbiter;

    localparam int IWD = 4;
    localparam int NALU = 2;
    localparam int NLSU = 2;
    localparam int DIVLAT = 16;
    localparam int LSUC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         redir;
    logic [3:0]   req_valid;
    logic [19:0]  req_fu;
    logic [3:0]   lsu_release;
    logic [4:0]   fu_ready;
    logic [3:0]   issue;
    logic [19:0]  grant_fu;
    logic [3:0]   lsu_avail;
`ifdef FU_ARB_PERF_EN
    logic [159:0] perf_stall;
`endif

    fu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .redir      (redir),
        .req_valid  (req_valid),
        .req_fu     (req_fu),
        .lsu_release(lsu_release),
        .fu_ready   (fu_ready),
        .issue      (issue),
        .grant_fu   (grant_fu),
        .lsu_avail  (lsu_avail)
`ifdef FU_ARB_PERF_EN
        ,
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           tag;
        logic [3:0]   issue;
        logic [19:0]  grant;
        logic [4:0]   rdy;
        logic [3:0]   avail;
        logic [159:0] perf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: divider is free from cycle m_div_free onward
    int   cyc = 0;
    int   m_div_free = 0;
    int   m_cred = LSUC;
    int   m_perf[5] = '{0, 0, 0, 0, 0};

    function automatic void chk(string name, int tag, logic [159:0] act, logic [159:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, tag, act, expv);
        end
    endfunction

    // One driven cycle: apply inputs, predict outputs, advance the model
    task automatic drive(input logic r, input logic [3:0] v, input logic [19:0] f, input int rel);
        exp_t e;
        int   bud[5];
        int   lsu_g;
        bit   div_g;
        bit   got;
        logic [4:0] den;
        @(posedge clk);
        #1;
        rst = 1'b0;
        redir = r;
        req_valid = v;
        req_fu = f;
        lsu_release = 4'(rel);
        e.tag   = cyc;
        e.rdy   = {m_cred != 0, cyc >= m_div_free, 3'b111};
        e.avail = 4'(m_cred);
        e.issue = '0;
        e.grant = '0;
        e.perf  = '0;
        for (int c = 0; c < 5; c++) e.perf[c*32 +: 32] = 32'(m_perf[c]);
        den = '0;
        if (r) begin
            m_div_free = cyc + 1;
            m_cred = LSUC;
        end else begin
            bud[0] = NALU;
            bud[1] = 1;
            bud[2] = 1;
            bud[3] = (cyc >= m_div_free) ? 1 : 0;
            bud[4] = (m_cred < NLSU) ? m_cred : NLSU;
            lsu_g = 0;
            div_g = 0;
            for (int i = 0; i < IWD; i++) begin
                if (v[i]) begin
                    got = 0;
                    for (int c = 0; c < 5; c++) begin
                        if (!got && f[i*5 + c] && bud[c] > 0) begin
                            got = 1;
                            bud[c]--;
                            e.issue[i] = 1'b1;
                            e.grant[i*5 + c] = 1'b1;
                            if (c == 4) lsu_g++;
                            if (c == 3) div_g = 1;
                        end
                    end
                    if (!got) den = den | f[i*5 +: 5];
                end
            end
            if (div_g) m_div_free = cyc + DIVLAT;
            m_cred = m_cred - lsu_g + rel;
            if (m_cred > LSUC) m_cred = LSUC;
            for (int c = 0; c < 5; c++) if (den[c]) m_perf[c]++;
        end
        cyc++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 4'b0, 20'b0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        redir = 1'b0;
        req_valid = '0;
        req_fu = '0;
        lsu_release = '0;
        m_div_free = cyc + 1;
        m_cred = LSUC;
        for (int c = 0; c < 5; c++) m_perf[c] = 0;
        cyc++;
    endtask

    function automatic logic [19:0] all4(input logic [4:0] m);
        return {m, m, m, m};
    endfunction

    // Monitor: compare every predicted cycle against the DUT mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue", e.tag, 160'(issue), 160'(e.issue));
                chk("grant_fu", e.tag, 160'(grant_fu), 160'(e.grant));
                chk("fu_ready", e.tag, 160'(fu_ready), 160'(e.rdy));
                chk("lsu_avail", e.tag, 160'(lsu_avail), 160'(e.avail));
`ifdef FU_ARB_PERF_EN
                chk("perf_stall", e.tag, perf_stall, e.perf);
`endif
            end
        end
    end

    // Watchdog against a stalled run
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Driver: directed scenarios, then random traffic
    initial begin
        logic [19:0] f;
        logic [3:0]  v;
        rst = 1'b1;
        redir = 1'b0;
        req_valid = '0;
        req_fu = '0;
        lsu_release = '0;
        repeat (2) @(posedge clk);
        cyc = 0;
        m_div_free = 0;
        m_cred = LSUC;

        // reset state, then four ALU-only requests: two granted
        idle(1);
        drive(1'b0, 4'hf, all4(5'b00001), 0);

        // divider occupancy: grant, denied at +5, granted again at +16
        drive(1'b0, 4'b0001, 20'(5'b01000), 0);
        idle(4);
        drive(1'b0, 4'b0001, 20'(5'b01000), 0);
        idle(10);
        drive(1'b0, 4'b0001, 20'(5'b01000), 0);

        // drain credits to 1, then mixed ALU|LSU requests
        repeat (3) drive(1'b0, 4'hf, all4(5'b10000), 0);
        drive(1'b0, 4'b0001, 20'(5'b10000), 0);
        drive(1'b0, 4'hf, all4(5'b10001), 0);
        drive(1'b0, 4'hf, all4(5'b10001), 0);

        // zero credits with same-cycle release: request denied
        drive(1'b0, 4'b0001, 20'(5'b10000), 3);
        idle(1);

        // redirect with divider mid-flight and two credits
        drive(1'b0, 4'b0001, 20'(5'b10000), 0);
        idle(16);
        drive(1'b0, 4'b0001, 20'(5'b01000), 0);
        idle(6);
        drive(1'b1, 4'hf, all4(5'b11111), 2);
        idle(2);

        // reset mid-divide
        drive(1'b0, 4'b0010, 20'(5'b01000) << 5, 0);
        idle(3);
        do_reset();
        idle(2);

        // ALU pressure: three ALU-only slots for ten cycles, then redirect
        for (int k = 0; k < 10; k++) drive(1'b0, 4'b0111, all4(5'b00001), 0);
        drive(1'b1, 4'b0111, all4(5'b00001), 0);
        idle(2);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            v = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 0) f[i*5 +: 5] = 5'(1 << $urandom_range(0, 4));
                else                           f[i*5 +: 5] = 5'($urandom);
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 19) == 0, v, f, $urandom_range(0, LSUC - m_cred));
            end
        end

        idle(1);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
